// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage sequencer: FSM state encoding,
// MemtoReg field encoding and a register-match helper for hazard detection.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // MemtoReg encoding; upstream decodes mem_rd as MemtoReg == MEMTOREG_MEM.
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  // r0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (dst != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request port. Handshake: dmem_req stays high from issue until the
// cycle the memory raises dmem_ack (or the access is aborted); dmem_we qualifies it.
interface mem_stage_ctrl_if;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output dmem_req, output dmem_we, input dmem_ack);
  modport slave  (input dmem_req, input dmem_we, output dmem_ack);
endinterface

// File: rtl/mem_stage_ctrl_hazard_detect.sv
// Raw load-use and branch-flush detection; priority against memory stalls is
// resolved by the parent.
module mem_stage_ctrl_hazard_detect
  import mem_stage_ctrl_pkg::*;
(
    input  logic       ex_is_load,
    input  logic [4:0] ex_wr_reg,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       branch_taken,
    output logic       load_use,
    output logic       branch_flush
);

    assign load_use = ex_is_load &
                      (reg_hit(id_rs, ex_wr_reg) | (id_uses_rt & reg_hit(id_rt, ex_wr_reg)));
    assign branch_flush = branch_taken;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: issues the dmem request for EX/MEM, freezes the front of
// the pipeline while an access is pending, aborts hung accesses, counts stalls.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_stage_ctrl_if.master    dmem,
    input  logic                mem_valid,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic                ex_is_load,
    input  logic [4:0]          ex_wr_reg,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic                id_uses_rt,
    input  logic                branch_taken,
    output logic                stall_pc,
    output logic                stall_if_id,
    output logic                hold_ex_front,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic                bubble_mem_wb,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    stall_cycles,
    output state_t              state_dbg
);

    localparam int WC_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            access, req, mem_stall, in_abort;
    logic            load_use, branch_flush;

    assign access        = mem_valid & (mem_rd | mem_wr);
    assign dmem.dmem_req = req;
    assign dmem.dmem_we  = mem_wr & req;
    assign state_dbg     = state;

    mem_stage_ctrl_hazard_detect u_hazard (
        .ex_is_load   (ex_is_load),
        .ex_wr_reg    (ex_wr_reg),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .branch_taken (branch_taken),
        .load_use     (load_use),
        .branch_flush (branch_flush)
    );

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req          = 1'b0;
        mem_stall    = 1'b0;
        in_abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                req = access;
                if (access && !dmem.dmem_ack) begin
                    mem_stall    = 1'b1;
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (dmem.dmem_ack) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == WC_LAST) begin
                        state_nxt    = ST_ABORT;
                        wait_cnt_nxt = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WC_W'(1);
                    end
                end
            end
            ST_ABORT: begin
                // Request dropped; any late ack this cycle is deliberately ignored.
                in_abort  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With EX frozen by a memory stall, branch and load-use wait for release.
    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        hold_ex_front = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_mem_wb = mem_stall | in_abort;
        if (mem_stall) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            hold_ex_front = 1'b1;
        end else if (branch_flush) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            timeout_err  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (in_abort) timeout_err <= 1'b1;
            if (stall_pc && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized plus directed bench for mem_stage_ctrl: a request-age reference model
// predicts every cycle's outputs into a queue that a negedge monitor drains.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int T   = 16;
  localparam int CW  = 6;
  localparam int W   = 11 + CW;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_valid, mem_rd, mem_wr, ex_is_load, id_uses_rt, branch_taken;
  logic [4:0] ex_wr_reg, id_rs, id_rt;
  logic stall_pc, stall_if_id, hold_ex_front, flush_if_id, flush_id_ex;
  logic bubble_mem_wb, timeout_err;
  logic [CW-1:0] stall_cycles;
  state_t state_dbg;

  mem_stage_ctrl_if dif ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dmem          (dif.master),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .ex_is_load    (ex_is_load),
    .ex_wr_reg     (ex_wr_reg),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .branch_taken  (branch_taken),
    .stall_pc      (stall_pc),
    .stall_if_id   (stall_if_id),
    .hold_ex_front (hold_ex_front),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .bubble_mem_wb (bubble_mem_wb),
    .timeout_err   (timeout_err),
    .stall_cycles  (stall_cycles),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model: age of the outstanding request in cycles, abort pending, sticky error
  bit m_busy, m_abort, m_err;
  int m_age, m_stalls;

  task automatic model_clear();
    m_busy = 0; m_abort = 0; m_err = 0; m_age = 0; m_stalls = 0;
  endtask

  task automatic clr_in();
    mem_valid = 0; mem_rd = 0; mem_wr = 0; dif.dmem_ack = 0;
    ex_is_load = 0; ex_wr_reg = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    branch_taken = 0;
  endtask

  task automatic tick();
    bit acc, req, we, stl, spc, sif, hold, fif, fie, bub, lu;
    logic [1:0] st;
    int age;
    acc = mem_valid && (mem_rd || mem_wr);
    req = 0; stl = 0; bub = 0; st = 2'd0;
    if (m_abort) begin
      st = 2'd2; bub = 1;
    end else if (m_busy) begin
      st = 2'd1; req = 1; stl = !dif.dmem_ack;
    end else begin
      req = acc; stl = acc && !dif.dmem_ack;
    end
    we = mem_wr && req;
    lu = ex_is_load && ex_wr_reg != 0 &&
         (id_rs == ex_wr_reg || (id_uses_rt && id_rt == ex_wr_reg));
    spc = 0; sif = 0; hold = 0; fif = 0; fie = 0;
    if (stl) begin
      spc = 1; sif = 1; hold = 1; bub = 1;
    end else if (branch_taken) begin
      fif = 1; fie = 1;
    end else if (lu) begin
      spc = 1; sif = 1; fie = 1;
    end
    exp_q.push_back({req, we, spc, sif, hold, fif, fie, bub, m_err, CW'(m_stalls), st});
    if (!reset_n) begin
      model_clear();
    end else begin
      if (spc && m_stalls < SAT) m_stalls++;
      if (m_abort) begin
        m_err = 1; m_abort = 0;
      end else if (stl) begin
        age = m_busy ? m_age + 1 : 1;
        if (age == T) begin
          m_abort = 1; m_busy = 0;
        end else begin
          m_busy = 1; m_age = age;
        end
      end else begin
        m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // monitor
  logic [W-1:0] act, exp_v;
  assign act = {dif.dmem_req, dif.dmem_we, stall_pc, stall_if_id, hold_ex_front,
                flush_if_id, flush_id_ex, bubble_mem_wb, timeout_err, stall_cycles,
                state_dbg};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (act !== exp_v) begin
        n_bad++;
        $display("FAIL cyc=%0d outputs {req,we,spc,sif,hold,fif,fie,bub,err,cnt,st} got=%b expected=%b",
                 cyc, act, exp_v);
      end
    end
  end

  // stimulus
  initial begin
    int ack_pct;
    reset_n = 0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    model_clear();
    tick();  // reset state

    // zero-wait store
    mem_valid = 1; mem_wr = 1; dif.dmem_ack = 1; tick();
    clr_in(); tick();

    // load acked after 3 stall cycles
    mem_valid = 1; mem_rd = 1;
    repeat (3) tick();
    dif.dmem_ack = 1; tick();
    clr_in(); tick();

    // load never acked: timeout, abort, late ack ignored
    mem_valid = 1; mem_rd = 1;
    repeat (T) tick();
    clr_in(); dif.dmem_ack = 1; tick();
    tick();
    clr_in(); repeat (2) tick();

    // load-use via rs, r0 destination, via rt, rt unused
    ex_is_load = 1; ex_wr_reg = 5; id_rs = 5; tick();
    ex_wr_reg = 0; id_rs = 0; tick();
    ex_wr_reg = 7; id_rs = 1; id_rt = 7; id_uses_rt = 1; tick();
    id_uses_rt = 0; tick();
    clr_in(); tick();

    // branch during wait, then held across ack
    mem_valid = 1; mem_rd = 1; branch_taken = 1;
    repeat (2) tick();
    dif.dmem_ack = 1; tick();
    mem_valid = 0; mem_rd = 0; dif.dmem_ack = 0; tick();
    clr_in(); tick();

    // reset in the second wait cycle
    mem_valid = 1; mem_rd = 1;
    repeat (2) tick();
    reset_n = 0; tick();
    reset_n = 1; clr_in(); repeat (2) tick();

    // randomized traffic
    ack_pct = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) ack_pct = $urandom_range(0, 3) * 20;
      if (!m_busy) begin
        mem_valid = $urandom_range(0, 1);
        mem_rd    = $urandom_range(0, 1);
        mem_wr    = !mem_rd && ($urandom_range(0, 2) != 0);
      end
      dif.dmem_ack = ($urandom_range(0, 99) < ack_pct);
      ex_is_load   = $urandom_range(0, 1);
      ex_wr_reg    = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = $urandom_range(0, 1);
      branch_taken = ($urandom_range(0, 5) == 0);
      reset_n      = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1;
    clr_in();
    tick();

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain leftover=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
